// File: rtl/fifo_burst_reader_pkg.sv
// Shared constants for the FIFO burst reader.
// State encoding and the syn_fifo read latency.
package fifo_burst_reader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int FIFO_RD_LATENCY = 1;

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry skid buffer with same-cycle bypass.
// Absorbs the FIFO read latency and sink backpressure.
module fifo_burst_reader_skid #(
    parameter int W = 18
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occ
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         pop;
    logic         keep;

    assign out_valid = occ != 2'd0 || in_valid;
    assign out_data  = (occ == 2'd0 && in_valid) ? in_data : mem0;
    assign pop       = out_valid && out_ready;
    // a bypassed beat taken on arrival is never stored
    assign keep      = in_valid && !(pop && occ == 2'd0);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            occ  <= 2'd0;
            mem0 <= '0;
            mem1 <= '0;
        end else begin
            if (pop && occ != 2'd0) begin
                mem0 <= mem1;
            end
            if (keep) begin
                if (occ == 2'd2 || (occ == 2'd1 && !pop)) begin
                    mem1 <= in_data;
                end else begin
                    mem0 <= in_data;
                end
            end
            occ <= occ + {1'b0, in_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains syn_fifo in fixed-length framed bursts onto a valid/ready stream.
// Short bursts are flushed after a run of idle cycles.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int BURST_LEN  = 64,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    output logic                  fifo_rd_en,
    input  logic [WIDTH-1:0]      fifo_dout,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH-1:0] fifo_cnt,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eof,
    output logic                  busy
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [LW-1:0] BLEN     = LW'(BURST_LEN);
    localparam logic [LW-1:0] ONE_L    = LW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]                 state;
    logic [LW-1:0]              level;
    logic [LW-1:0]              rem;
    logic [TW-1:0]              idle_tmr;
    logic [FIFO_RD_LATENCY-1:0] pend;
    logic                       in_flight;
    logic                       pend_sof;
    logic                       pend_eof;
    logic                       first;
    logic [1:0]                 occ;
    logic                       full_go;
    logic                       tmo_go;
    logic                       pop;
    logic                       last_rd;
    logic [2:0]                 after_pop;
    logic [WIDTH+1:0]           out_beat;

    // a full FIFO reports fifo_cnt==0 while not empty
    assign level = (fifo_cnt == '0 && !fifo_empty) ? FULL_LVL
                                                   : {1'b0, fifo_cnt};

    assign full_go   = level >= BLEN;
    assign tmo_go    = !fifo_empty && idle_tmr == TMO_LAST;
    assign in_flight = |pend;
    assign pop       = m_valid && m_ready;
    assign after_pop = {1'b0, occ} + {2'b0, in_flight} - {2'b0, pop};

    assign fifo_rd_en = state == ST_BURST && rem != '0
                        && !fifo_empty && after_pop < 3'd2;
    assign last_rd    = fifo_rd_en && rem == ONE_L;
    assign busy       = state != ST_IDLE;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            rem      <= '0;
            idle_tmr <= '0;
            first    <= 1'b0;
            pend     <= '0;
            pend_sof <= 1'b0;
            pend_eof <= 1'b0;
        end else begin
            pend     <= FIFO_RD_LATENCY'({pend, fifo_rd_en});
            pend_sof <= fifo_rd_en && first;
            pend_eof <= last_rd;
            if (fifo_rd_en) begin
                first <= 1'b0;
                rem   <= rem - ONE_L;
            end
            case (state)
                ST_IDLE: begin
                    if (full_go || tmo_go) begin
                        state    <= ST_BURST;
                        rem      <= full_go ? BLEN : level;
                        first    <= 1'b1;
                        idle_tmr <= '0;
                    end else if (fifo_empty) begin
                        idle_tmr <= '0;
                    end else begin
                        idle_tmr <= idle_tmr + TW'(1);
                    end
                end
                ST_BURST: begin
                    if (last_rd || rem == '0) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (occ == 2'd0 && !in_flight) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fifo_burst_reader_skid #(
        .W(WIDTH + 2)
    ) u_skid (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .in_valid (pend[FIFO_RD_LATENCY-1]),
        .in_data  ({pend_sof, pend_eof, fifo_dout}),
        .out_valid(m_valid),
        .out_data (out_beat),
        .out_ready(m_ready),
        .occ      (occ)
    );

    assign m_sof  = out_beat[WIDTH+1];
    assign m_eof  = out_beat[WIDTH];
    assign m_data = out_beat[WIDTH-1:0];

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader with a behavioural 512-deep syn_fifo.
// Expected beats come from a framing model of the written words.
module tb_fifo_burst_reader;

    localparam int W     = 16;
    localparam int AW    = 9;
    localparam int BL    = 64;
    localparam int TMO   = 1000;
    localparam int DEPTH = 512;

    typedef struct packed {
        logic [W-1:0] d;
        logic         sof;
        logic         eof;
    } beat_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          fifo_rst;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_dout;
    logic          fifo_empty;
    logic [AW-1:0] fifo_cnt;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sof;
    logic          m_eof;
    logic          busy;
    logic          wr_en;
    logic [W-1:0]  wr_data;

    logic [W-1:0]  fmem [DEPTH];
    int unsigned   wp;
    int unsigned   rp;
    int unsigned   fcount;
    logic          do_wr;
    logic          do_rd;

    always #5 sys_clk = ~sys_clk;

    assign fifo_empty = fcount == 0;
    assign fifo_cnt   = AW'(fcount);
    assign do_wr      = wr_en && fcount < DEPTH;
    assign do_rd      = fifo_rd_en && fcount != 0;

    always @(posedge sys_clk) begin
        if (fifo_rst) begin
            wp        <= 0;
            rp        <= 0;
            fcount    <= 0;
            fifo_dout <= '0;
        end else begin
            if (do_wr) begin
                fmem[wp] <= wr_data;
                wp       <= (wp + 1) % DEPTH;
            end
            if (do_rd) begin
                fifo_dout <= fmem[rp];
                rp        <= (rp + 1) % DEPTH;
            end
            fcount <= fcount + 32'(do_wr) - 32'(do_rd);
        end
    end

    fifo_burst_reader #(
        .WIDTH     (W),
        .ADDR_WIDTH(AW),
        .BURST_LEN (BL),
        .TIMEOUT   (TMO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_cnt  (fifo_cnt),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sof     (m_sof),
        .m_eof     (m_eof),
        .busy      (busy)
    );

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    beat_t exp_q [$];
    logic [W-1:0] stage [$];
    bit    rdy_rand = 0;
    int    beats = 0;
    int    eofs = 0;
    int    sof_s = 0;
    int    span = 0;
    int    run = 0;
    int    run_start = 0;
    int    last_run = 0;
    int    rise_s = 0;
    bit    rise_rd = 0;
    int    first_val_s = 0;
    bit    val_seen = 0;
    bit    arm_hit = 0;
    int    hit_s = 0;
    int    idle_valid = 0;
    bit    busy_prev = 0;
    bit    stall_prev = 0;
    beat_t prev_beat;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     tag, got, want, cyc);
        end
    endtask

    task automatic sample();
        beat_t cur;
        beat_t e;
        cur = {m_data, m_sof, m_eof};
        if (stall_prev && !sys_rst) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_beat", 32'(cur), 32'(prev_beat));
        end
        stall_prev = m_valid && !m_ready;
        prev_beat  = cur;
        if (fifo_rd_en) chk("rd_when_empty", 32'(fifo_empty), 32'd0);
        if (m_valid && !busy) idle_valid++;
        if (busy && !busy_prev) begin
            last_run = run;
            rise_s   = cyc;
            rise_rd  = fifo_rd_en;
            val_seen = 0;
        end
        if (busy && m_valid && !val_seen) begin
            val_seen    = 1;
            first_val_s = cyc;
        end
        if (arm_hit && !busy && fcount >= BL) begin
            hit_s   = cyc;
            arm_hit = 0;
        end
        if (!busy && fcount != 0) begin
            if (run == 0) run_start = cyc;
            run++;
        end else begin
            run = 0;
        end
        busy_prev = busy;
        if (m_valid && m_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'(m_data), 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(m_data), 32'(e.d));
                chk("beat_sof", 32'(m_sof), 32'(e.sof));
                chk("beat_eof", 32'(m_eof), 32'(e.eof));
            end
            if (m_sof) sof_s = cyc;
            if (m_eof) begin
                eofs++;
                span = cyc - sof_s;
            end
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        m_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        #1;
        cyc++;
        sample();
    endtask

    task automatic stage_seq(input int base, input int n);
        stage.delete();
        for (int i = 0; i < n; i++) stage.push_back(W'(base + i));
    endtask

    task automatic stage_rand(input int n);
        stage.delete();
        for (int i = 0; i < n; i++) stage.push_back(W'($urandom));
    endtask

    // every BL words form a burst; any remainder is one short burst
    task automatic commit(input int blen);
        beat_t e;
        int    n;
        n = stage.size();
        for (int i = 0; i < n; i++) begin
            e.d   = stage[i];
            e.sof = (i % blen) == 0;
            e.eof = (i % blen) == blen - 1 || i == n - 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic write_range(input int from, input int to,
                               input int gap_max);
        for (int i = from; i < to; i++) begin
            wr_en   = 1'b1;
            wr_data = stage[i];
            tick();
            wr_en = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || fcount != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int e0;
        int b0;
        int g;
        int n;
        wr_en    = 1'b0;
        wr_data  = '0;
        m_ready  = 1'b1;
        sys_rst  = 1'b1;
        fifo_rst = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_sof", 32'(m_sof), 32'd0);
        chk("rst_eof", 32'(m_eof), 32'd0);
        sys_rst  = 1'b0;
        fifo_rst = 1'b0;
        tick();

        stage_seq(1, 200);
        commit(BL);
        write_range(0, 200, 0);
        wait_done("t1_done", 2500);
        chk("t1_flush_idle", 32'(last_run), 32'(TMO));
        chk("t1_flush_lat", 32'(first_val_s - rise_s), 32'd1);
        chk("t1_flush_span", 32'(span), 32'd7);

        rdy_rand = 1;
        stage_seq(1, 128);
        commit(BL);
        write_range(0, 128, 0);
        wait_done("t2_done", 3000);
        rdy_rand = 0;

        sys_rst = 1'b1;
        stage_seq(1, DEPTH);
        commit(BL);
        e0 = eofs;
        write_range(0, DEPTH, 0);
        sys_rst = 1'b0;
        wait_done("t3_done", 3000);
        chk("t3_bursts", 32'(eofs - e0), 32'd8);
        chk("t3_empty", 32'(fifo_empty), 32'd1);

        stage_rand(63);
        commit(BL);
        e0 = eofs;
        write_range(0, 63, 0);
        wait_done("t4a_done", 2500);
        chk("t4a_idle", 32'(last_run), 32'(TMO));
        chk("t4a_span", 32'(span), 32'd62);
        chk("t4a_bursts", 32'(eofs - e0), 32'd1);

        stage_rand(64);
        commit(BL);
        e0 = eofs;
        write_range(0, 63, 0);
        g = 0;
        while (cyc < run_start + TMO - 2 && g < 2 * TMO) begin
            tick();
            g++;
        end
        wr_en   = 1'b1;
        wr_data = stage[63];
        tick();
        wr_en = 1'b0;
        wait_done("t4b_done", 500);
        chk("t4b_span", 32'(span), 32'd63);
        chk("t4b_bursts", 32'(eofs - e0), 32'd1);
        chk("t4b_idle", 32'(last_run), 32'(TMO));

        stage_seq(16'h0500, 64);
        commit(BL);
        e0 = eofs;
        b0 = beats;
        write_range(0, 64, 0);
        g = 0;
        while (beats - b0 < 10 && g < 200) begin
            tick();
            g++;
        end
        chk("t5_started", 32'(beats - b0 >= 10), 32'd1);
        sys_rst  = 1'b1;
        fifo_rst = 1'b1;
        exp_q.delete();
        tick();
        chk("t5_valid", 32'(m_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_no_eof", 32'(eofs - e0), 32'd0);
        sys_rst  = 1'b0;
        fifo_rst = 1'b0;
        tick();
        stage_seq(16'h0600, 64);
        commit(BL);
        write_range(0, 64, 0);
        wait_done("t5_done", 500);

        stage_rand(64);
        commit(BL);
        arm_hit = 1;
        write_range(0, 64, 0);
        wait_done("t6_done", 500);
        chk("t6_busy_lat", 32'(rise_s - hit_s), 32'd1);
        chk("t6_rd_en", 32'(rise_rd), 32'd1);
        chk("t6_valid_lat", 32'(first_val_s - rise_s), 32'd1);
        chk("t6_span", 32'(span), 32'd63);

        rdy_rand = 1;
        n = $urandom_range(100, 300);
        stage_rand(n);
        commit(BL);
        write_range(0, n, 3);
        wait_done("t7_done", 4000);
        rdy_rand = 0;

        chk("valid_while_idle", 32'(idle_valid), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
